// File: rtl/alu_cdb_unit_pkg.sv
// rtl/alu_cdb_unit_pkg.sv - shared constants, op codes and CDB entry type for the ALU unit
package alu_cdb_unit_pkg;

  localparam int OPERATION_BUS  = 6;
  localparam int ROB_WIDTH      = 4;
  localparam int ALU_FIFO_DEPTH = 4;
  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  typedef enum logic [OPERATION_BUS-1:0] {
    NOP      = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_SLL   = 6'd6,
    OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,
    OP_SLT   = 6'd9,
    OP_SLTU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_ANDI  = 6'd12,
    OP_ORI   = 6'd13,
    OP_XORI  = 6'd14,
    OP_SLLI  = 6'd15,
    OP_SRLI  = 6'd16,
    OP_SRAI  = 6'd17,
    OP_SLTI  = 6'd18,
    OP_SLTIU = 6'd19,
    OP_LUI   = 6'd20,
    OP_AUIPC = 6'd21,
    OP_JAL   = 6'd22,
    OP_JALR  = 6'd23,
    OP_BEQ   = 6'd24,
    OP_BNE   = 6'd25,
    OP_BLT   = 6'd26,
    OP_BGE   = 6'd27,
    OP_BLTU  = 6'd28,
    OP_BGEU  = 6'd29
  } alu_op_e;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_entry_t;

  // Ops that resolve control flow and drive the branch outputs.
  function automatic logic is_control(alu_op_e op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLT) || (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

endpackage

// File: rtl/alu_cdb_unit_result_fifo.sv
// rtl/alu_cdb_unit_result_fifo.sv - small result FIFO holding results waiting for the CDB
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cdb_unit.sv
// rtl/alu_cdb_unit.sv - integer ALU with queued CDB broadcast and registered branch resolution
module alu_cdb_unit
  import alu_cdb_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     clear,
  input  logic [OPERATION_BUS-1:0] in_op,
  input  logic [31:0]              in_Vj,
  input  logic [31:0]              in_Vk,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_imm,
  input  logic [ROB_WIDTH-1:0]     in_rob_tag,
  output logic                     out_ready,
  input  logic                     cdb_stall,
  output logic [ROB_WIDTH-1:0]     out_cdb_rob_tag,
  output logic [31:0]              out_cdb_data,
  output logic                     out_br_valid,
  output logic                     out_br_taken,
  output logic [31:0]              out_br_target
);

  alu_op_e     op;
  logic [31:0] result;
  logic        cond;
  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] pc_imm;
  logic        accept;
  logic        enq;
  logic        bypass;
  logic        pop;
  logic        push;
  logic        fifo_full;
  logic        fifo_empty;
  cdb_entry_t  head;
  cdb_entry_t  new_entry;

  assign op        = alu_op_e'(in_op);
  assign pc_plus4  = in_pc + 32'd4;
  assign pc_imm    = in_pc + in_imm;

  always_comb begin
    result = '0;
    cond   = 1'b0;
    taken  = 1'b0;
    target = pc_plus4;
    case (op)
      OP_ADD:   result = in_Vj + in_Vk;
      OP_SUB:   result = in_Vj - in_Vk;
      OP_AND:   result = in_Vj & in_Vk;
      OP_OR:    result = in_Vj | in_Vk;
      OP_XOR:   result = in_Vj ^ in_Vk;
      OP_SLL:   result = in_Vj << in_Vk[4:0];
      OP_SRL:   result = in_Vj >> in_Vk[4:0];
      OP_SRA:   result = $signed(in_Vj) >>> in_Vk[4:0];
      OP_SLT:   result = {31'd0, $signed(in_Vj) < $signed(in_Vk)};
      OP_SLTU:  result = {31'd0, in_Vj < in_Vk};
      OP_ADDI:  result = in_Vj + in_imm;
      OP_ANDI:  result = in_Vj & in_imm;
      OP_ORI:   result = in_Vj | in_imm;
      OP_XORI:  result = in_Vj ^ in_imm;
      OP_SLLI:  result = in_Vj << in_imm[4:0];
      OP_SRLI:  result = in_Vj >> in_imm[4:0];
      OP_SRAI:  result = $signed(in_Vj) >>> in_imm[4:0];
      OP_SLTI:  result = {31'd0, $signed(in_Vj) < $signed(in_imm)};
      OP_SLTIU: result = {31'd0, in_Vj < in_imm};
      OP_LUI:   result = in_imm;
      OP_AUIPC: result = pc_imm;
      OP_JAL: begin
        result = pc_plus4;
        taken  = 1'b1;
        target = pc_imm;
      end
      OP_JALR: begin
        result = pc_plus4;
        taken  = 1'b1;
        target = (in_Vj + in_imm) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  cond = (in_Vj == in_Vk);
          OP_BNE:  cond = (in_Vj != in_Vk);
          OP_BLT:  cond = ($signed(in_Vj) < $signed(in_Vk));
          OP_BGE:  cond = ($signed(in_Vj) >= $signed(in_Vk));
          OP_BLTU: cond = (in_Vj < in_Vk);
          default: cond = (in_Vj >= in_Vk);
        endcase
        taken  = cond;
        target = cond ? pc_imm : pc_plus4;
      end
      default: result = '0;
    endcase
  end

  // With an empty FIFO and a free slot, the result goes straight to the output
  // register so a lone op broadcasts the cycle after it is accepted.
  assign out_ready = ena & ~fifo_full;
  assign accept    = out_ready & (op != NOP) & ~clear;
  assign enq       = accept & (in_rob_tag != ZERO_ROB);
  assign bypass    = enq & fifo_empty & ~cdb_stall;
  assign push      = enq & ~bypass;
  assign pop       = ena & ~clear & ~fifo_empty & ~cdb_stall;
  assign new_entry = '{tag: in_rob_tag, data: result};

  result_fifo #(
    .DEPTH(ALU_FIFO_DEPTH),
    .WIDTH($bits(cdb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (new_entry),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cdb_rob_tag <= ZERO_ROB;
      out_cdb_data    <= '0;
      out_br_valid    <= 1'b0;
      out_br_taken    <= 1'b0;
      out_br_target   <= '0;
    end else if (clear) begin
      out_cdb_rob_tag <= ZERO_ROB;
      out_br_valid    <= 1'b0;
    end else if (ena) begin
      if (pop) begin
        out_cdb_rob_tag <= head.tag;
        out_cdb_data    <= head.data;
      end else if (bypass) begin
        out_cdb_rob_tag <= in_rob_tag;
        out_cdb_data    <= result;
      end else begin
        out_cdb_rob_tag <= ZERO_ROB;
      end
      out_br_valid <= accept & is_control(op);
      if (accept && is_control(op)) begin
        out_br_taken  <= taken;
        out_br_target <= target;
      end
    end
  end

endmodule

// File: tb/tb_alu_cdb_unit.sv
// tb/tb_alu_cdb_unit.sv - scoreboard bench for alu_cdb_unit
module tb_alu_cdb_unit;
  import alu_cdb_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ena, clear, cdb_stall;
  logic [5:0]  in_op;
  logic [31:0] in_Vj, in_Vk, in_pc, in_imm;
  logic [3:0]  in_rob_tag;
  logic        out_ready, out_br_valid, out_br_taken;
  logic [3:0]  out_cdb_rob_tag;
  logic [31:0] out_cdb_data, out_br_target;

  int vectors = 0;
  int miscompares = 0;

  logic [35:0] sb_q[$];
  logic [3:0]  m_tag;
  logic [31:0] m_data, m_btg;
  logic        m_bv, m_bt;

  alu_cdb_unit dut (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .in_op(in_op),
    .in_Vj(in_Vj), .in_Vk(in_Vk), .in_pc(in_pc), .in_imm(in_imm),
    .in_rob_tag(in_rob_tag), .out_ready(out_ready), .cdb_stall(cdb_stall),
    .out_cdb_rob_tag(out_cdb_rob_tag), .out_cdb_data(out_cdb_data),
    .out_br_valid(out_br_valid), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [5:0] op, input logic [31:0] a, b, pc, imm,
                                output logic [31:0] r, output logic bv, bt,
                                output logic [31:0] tg);
    r = 0; bv = 0; bt = 0; tg = 0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLL:   r = a << b[4:0];
      OP_SRL:   r = a >> b[4:0];
      OP_SRA:   r = $signed(a) >>> b[4:0];
      OP_SLT:   r = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU:  r = (a < b) ? 1 : 0;
      OP_ADDI:  r = a + imm;
      OP_ANDI:  r = a & imm;
      OP_ORI:   r = a | imm;
      OP_XORI:  r = a ^ imm;
      OP_SLLI:  r = a << imm[4:0];
      OP_SRLI:  r = a >> imm[4:0];
      OP_SRAI:  r = $signed(a) >>> imm[4:0];
      OP_SLTI:  r = ($signed(a) < $signed(imm)) ? 1 : 0;
      OP_SLTIU: r = (a < imm) ? 1 : 0;
      OP_LUI:   r = imm;
      OP_AUIPC: r = pc + imm;
      OP_JAL:   begin r = pc + 4; bv = 1; bt = 1; tg = pc + imm; end
      OP_JALR:  begin r = pc + 4; bv = 1; bt = 1; tg = (a + imm) & 32'hFFFF_FFFE; end
      OP_BEQ:   begin bv = 1; bt = (a == b); end
      OP_BNE:   begin bv = 1; bt = (a != b); end
      OP_BLT:   begin bv = 1; bt = ($signed(a) < $signed(b)); end
      OP_BGE:   begin bv = 1; bt = ($signed(a) >= $signed(b)); end
      OP_BLTU:  begin bv = 1; bt = (a < b); end
      OP_BGEU:  begin bv = 1; bt = (a >= b); end
      default:  r = 0;
    endcase
    if (bv && op != OP_JAL && op != OP_JALR) tg = bt ? pc + imm : pc + 4;
  endfunction

  // Advance one clock: update the reference state from the current inputs, then compare.
  task automatic tick();
    logic [31:0] r, tg;
    logic bv, bt, acc;
    logic [35:0] e;
    model(in_op, in_Vj, in_Vk, in_pc, in_imm, r, bv, bt, tg);
    if (!rst) begin
      sb_q.delete();
      m_tag = 0; m_data = 0; m_bv = 0; m_bt = 0; m_btg = 0;
    end else if (clear) begin
      sb_q.delete();
      m_tag = 0; m_bv = 0;
    end else if (ena) begin
      acc = (in_op != 6'd0) && (sb_q.size() < 4);
      if (acc && in_rob_tag != 4'd0) sb_q.push_back({in_rob_tag, r});
      if (!cdb_stall && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        m_tag = e[35:32]; m_data = e[31:0];
      end else begin
        m_tag = 0;
      end
      m_bv = acc && bv;
      if (acc && bv) begin m_bt = bt; m_btg = tg; end
    end
    @(posedge clk); #1;
    check("cdb_tag",   {28'd0, out_cdb_rob_tag}, {28'd0, m_tag});
    check("cdb_data",  out_cdb_data, m_data);
    check("br_valid",  {31'd0, out_br_valid}, {31'd0, m_bv});
    check("br_taken",  {31'd0, out_br_taken}, {31'd0, m_bt});
    check("br_target", out_br_target, m_btg);
    check("ready",     {31'd0, out_ready}, {31'd0, ena && (sb_q.size() < 4)});
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, vk, pc, imm,
                       input logic [3:0] tag);
    in_op = op; in_Vj = vj; in_Vk = vk; in_pc = pc; in_imm = imm; in_rob_tag = tag;
  endtask

  task automatic idle();
    issue(6'd0, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    rst = 0; ena = 1; clear = 0; cdb_stall = 0;
    idle();
    m_tag = 0; m_data = 0; m_bv = 0; m_bt = 0; m_btg = 0;
    tick(); tick();
    check("reset_tag", {28'd0, out_cdb_rob_tag}, 32'd0);
    rst = 1;

    // ADD 5+7 tag 3: broadcast next cycle, idle after
    issue(OP_ADD, 5, 7, 0, 0, 4'd3); tick();
    check("add_tag", {28'd0, out_cdb_rob_tag}, 32'd3);
    check("add_data", out_cdb_data, 32'd12);
    idle(); tick();
    check("add_idle_tag", {28'd0, out_cdb_rob_tag}, 32'd0);

    // Five ADDIs under stall: four fit, fifth is refused
    cdb_stall = 1;
    for (int i = 1; i <= 5; i++) begin
      issue(OP_ADDI, 32'd100, 0, 0, i, 4'(i)); tick();
    end
    check("full_ready", {31'd0, out_ready}, 32'd0);
    idle(); cdb_stall = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_order", {28'd0, out_cdb_rob_tag}, i);
    end
    tick();
    check("drain_done", {28'd0, out_cdb_rob_tag}, 32'd0);

    // BLT signed, tag 0: branch only
    issue(OP_BLT, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 4'd0); tick();
    check("blt_valid", {31'd0, out_br_valid}, 32'd1);
    check("blt_target", out_br_target, 32'h120);
    check("blt_no_cdb", {28'd0, out_cdb_rob_tag}, 32'd0);

    // JALR with low-bit clear, tag 2
    issue(OP_JALR, 32'h203, 0, 32'h40, 0, 4'd2); tick();
    check("jalr_target", out_br_target, 32'h202);
    check("jalr_data", out_cdb_data, 32'h44);
    idle(); tick();
    check("br_one_cycle", {31'd0, out_br_valid}, 32'd0);

    // Two queued under stall, then flush
    cdb_stall = 1;
    issue(OP_ADD, 1, 1, 0, 0, 4'd6); tick();
    issue(OP_ADD, 2, 2, 0, 0, 4'd7); tick();
    idle(); clear = 1; tick();
    clear = 0; cdb_stall = 0;
    check("clear_ready", {31'd0, out_ready}, 32'd1);
    tick(); tick();

    // SRA uses only the low five shift bits
    issue(OP_SRA, 32'h8000_0000, 32'h21, 0, 0, 4'd9); tick();
    check("sra_data", out_cdb_data, 32'hC000_0000);

    // Reset with three queued entries
    cdb_stall = 1;
    for (int i = 1; i <= 3; i++) begin
      issue(OP_ORI, 0, 0, 0, 32'h10 + i, 4'(10 + i)); tick();
    end
    idle(); rst = 0; tick();
    check("rst_data", out_cdb_data, 32'd0);
    rst = 1; cdb_stall = 0;
    tick(); tick(); tick();

    // Randomised traffic with stall, enable and flush
    for (int n = 0; n < 300; n++) begin
      issue(6'($urandom_range(0, 29)), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
            $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
      cdb_stall = ($urandom_range(0, 9) < 3);
      ena       = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle(); ena = 1; clear = 0; cdb_stall = 0;
    for (int n = 0; n < 6; n++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
